// File: rtl/fft_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_ctrl_pkg
// Brief    : Shared types and constants for the FFT button sequencer.
// Revision : 1.0
// ============================================================================
package fft_ctrl_pkg;

    localparam int N_POINTS = 4;
    localparam int IDX_BITS = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_SHOW  = 3'd4,
        ST_ERR   = 3'd5
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft_button_ctrl
// Brief    : Button-driven sequencer: sample load, FFT launch with timeout,
//            output bin stepping. All outputs registered.
// Revision : 1.0
// ============================================================================
module fft_button_ctrl #(
    parameter int                        N_POINTS     = fft_ctrl_pkg::N_POINTS,
    parameter int                        IDX_BITS     = fft_ctrl_pkg::IDX_BITS,
    parameter int                        DATA_W       = 8,
    parameter int                        TIMEOUT_BITS = 16,
    parameter logic [TIMEOUT_BITS-1:0]   TIMEOUT_MAX  = TIMEOUT_BITS'(1000)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_pulse,
    input  logic                load_pulse,
    input  logic                start_pulse,
    input  logic                next_pulse,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic                fft_done,
    output logic                wr_en,
    output logic [IDX_BITS-1:0] wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                fft_start,
    output logic [IDX_BITS-1:0] disp_idx,
    output logic                busy,
    output logic                err,
    output logic [2:0]          state_o
);

    import fft_ctrl_pkg::*;

    localparam logic [IDX_BITS-1:0]     c_idx_last = IDX_BITS'(N_POINTS - 1);
    localparam logic [TIMEOUT_BITS-1:0] c_cnt_sat  = {TIMEOUT_BITS{1'b1}};

    ctrl_state_t             r_state,    w_state_nxt;
    logic [IDX_BITS-1:0]     r_idx,      w_idx_nxt;
    logic [IDX_BITS-1:0]     r_disp_idx, w_disp_idx_nxt;
    logic [IDX_BITS-1:0]     r_wr_addr,  w_wr_addr_nxt;
    logic [DATA_W-1:0]       r_wr_data,  w_wr_data_nxt;
    logic                    r_wr_en,    w_wr_en_nxt;
    logic                    r_fft_start, w_fft_start_nxt;
    logic [TIMEOUT_BITS-1:0] r_cnt,      w_cnt_nxt;
    logic                    r_busy;
    logic                    r_err;

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_disp_idx_nxt  = r_disp_idx;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_cnt_nxt       = r_cnt;
        w_wr_en_nxt     = 1'b0;
        w_fft_start_nxt = 1'b0;

        if (clear_pulse) begin
            w_state_nxt    = ST_IDLE;
            w_idx_nxt      = '0;
            w_disp_idx_nxt = '0;
            w_cnt_nxt      = '0;
        end else begin
            // Each branch tests start before load so a higher-priority pulse
            // swallows the lower ones even when it has no effect in this state.
            case (r_state)
                ST_IDLE: begin
                    if (!start_pulse && load_pulse) begin
                        w_state_nxt = ST_LOAD;
                        w_idx_nxt   = '0;
                    end
                end
                ST_LOAD: begin
                    if (!start_pulse && load_pulse) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_idx;
                        w_wr_data_nxt = sample_in;
                        w_idx_nxt     = r_idx + 1'b1;
                        if (r_idx == c_idx_last) begin
                            w_state_nxt = ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    if (start_pulse) begin
                        w_state_nxt     = ST_RUN;
                        w_fft_start_nxt = 1'b1;
                        w_cnt_nxt       = '0;
                    end else if (load_pulse) begin
                        w_state_nxt = ST_LOAD;
                        w_idx_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    if (fft_done) begin
                        w_state_nxt    = ST_SHOW;
                        w_disp_idx_nxt = '0;
                    end else if (r_cnt == TIMEOUT_MAX) begin
                        w_state_nxt = ST_ERR;
                    end else if (r_cnt != c_cnt_sat) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (start_pulse) begin
                        w_state_nxt     = ST_RUN;
                        w_fft_start_nxt = 1'b1;
                        w_cnt_nxt       = '0;
                    end else if (load_pulse) begin
                        w_state_nxt = ST_LOAD;
                        w_idx_nxt   = '0;
                    end else if (next_pulse) begin
                        w_disp_idx_nxt = r_disp_idx + 1'b1;
                    end
                end
                ST_ERR: begin
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_disp_idx  <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_fft_start <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_disp_idx  <= w_disp_idx_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_fft_start <= w_fft_start_nxt;
            r_busy      <= (w_state_nxt == ST_RUN);
            r_err       <= (w_state_nxt == ST_ERR);
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign fft_start = r_fft_start;
    assign disp_idx  = r_disp_idx;
    assign busy      = r_busy;
    assign err       = r_err;
    assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fft_button_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_button_ctrl
// Brief    : Directed self-checking bench for fft_button_ctrl.
// Revision : 1.0
// ============================================================================
module tb_fft_button_ctrl;

    logic       clk;
    logic       rst;
    logic       clear_pulse;
    logic       load_pulse;
    logic       start_pulse;
    logic       next_pulse;
    logic [7:0] sample_in;
    logic       fft_done;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       fft_start;
    logic [1:0] disp_idx;
    logic       busy;
    logic       err;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    fft_button_ctrl #(
        .N_POINTS    (4),
        .IDX_BITS    (2),
        .DATA_W      (8),
        .TIMEOUT_BITS(16),
        .TIMEOUT_MAX (16'd20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear_pulse(clear_pulse),
        .load_pulse (load_pulse),
        .start_pulse(start_pulse),
        .next_pulse (next_pulse),
        .sample_in  (sample_in),
        .fft_done   (fft_done),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fft_start  (fft_start),
        .disp_idx   (disp_idx),
        .busy       (busy),
        .err        (err),
        .state_o    (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle input vector; returns 1 ns after the edge that samples it.
    task automatic drive(input logic c, input logic l, input logic s, input logic n, input logic d);
        clear_pulse = c;
        load_pulse  = l;
        start_pulse = s;
        next_pulse  = n;
        fft_done    = d;
        tick();
        clear_pulse = 1'b0;
        load_pulse  = 1'b0;
        start_pulse = 1'b0;
        next_pulse  = 1'b0;
        fft_done    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_pulse = 1'b0;
        load_pulse  = 1'b0;
        start_pulse = 1'b0;
        next_pulse  = 1'b0;
        fft_done    = 1'b0;
        sample_in   = 8'h00;

        tick();
        tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_start", 32'(fft_start), 32'd0);
        chk("rst_busy_err", 32'({busy, err}), 32'd0);
        chk("rst_addr_data_disp", 32'({wr_addr, wr_data, disp_idx}), 32'd0);
        rst = 1'b0;
        tick();

        // Frame load: first pulse only enters LOAD, then four writes
        sample_in = 8'h99;
        drive(0, 1, 0, 0, 0);
        chk("t1_enter_load", 32'(state_o), 32'd1);
        chk("t1_enter_no_wr", 32'(wr_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            sample_in = 8'(8'h11 * (i + 1));
            drive(0, 1, 0, 0, 0);
            chk("t1_wr_en", 32'(wr_en), 32'd1);
            chk("t1_wr_addr", 32'(wr_addr), 32'(i));
            chk("t1_wr_data", 32'(wr_data), 32'(8'h11 * (i + 1)));
            chk("t1_state", 32'(state_o), (i == 3) ? 32'd2 : 32'd1);
        end
        tick();
        chk("t1_wr_en_1cyc", 32'(wr_en), 32'd0);

        // Run, complete after 10 cycles, step display
        drive(0, 0, 1, 0, 0);
        chk("t2_fft_start", 32'(fft_start), 32'd1);
        chk("t2_busy", 32'(busy), 32'd1);
        chk("t2_state_run", 32'(state_o), 32'd3);
        tick();
        chk("t2_fft_start_1cyc", 32'(fft_start), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        drive(0, 0, 0, 0, 1);
        chk("t2_state_show", 32'(state_o), 32'd4);
        chk("t2_disp_zero", 32'(disp_idx), 32'd0);
        chk("t2_busy_low", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 0);
            chk("t2_disp_idx", 32'(disp_idx), 32'((i + 1) % 4));
        end

        // Rerun from SHOW with no completion: timeout into ERR
        drive(0, 0, 1, 0, 0);
        chk("t3_rerun_start", 32'(fft_start), 32'd1);
        chk("t3_rerun_state", 32'(state_o), 32'd3);
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) begin
                drive(0, 1, 0, 0, 0);
                chk("t3_run_load_ign", 32'(wr_en), 32'd0);
            end else if (i == 6) begin
                drive(0, 0, 1, 0, 0);
                chk("t3_run_start_ign", 32'(fft_start), 32'd0);
            end else begin
                tick();
            end
        end
        chk("t3_still_run", 32'(state_o), 32'd3);
        tick();
        chk("t3_state_err", 32'(state_o), 32'd5);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_busy_low", 32'(busy), 32'd0);
        drive(0, 1, 0, 0, 0);
        chk("t3_err_load_ign", 32'({state_o, wr_en}), 32'({3'd5, 1'b0}));
        drive(0, 0, 1, 0, 0);
        chk("t3_err_start_ign", 32'({state_o, fft_start}), 32'({3'd5, 1'b0}));
        drive(1, 0, 0, 0, 0);
        chk("t3_clear_state", 32'(state_o), 32'd0);
        chk("t3_clear_err", 32'(err), 32'd0);

        // Same-cycle priority inside an incomplete frame
        drive(0, 1, 0, 0, 0);
        sample_in = 8'hA1;
        drive(0, 1, 0, 0, 0);
        sample_in = 8'hA2;
        drive(0, 1, 0, 0, 0);
        chk("t4_two_loaded", 32'({state_o, wr_addr}), 32'({3'd1, 2'd1}));
        sample_in = 8'hEE;
        drive(0, 1, 1, 0, 0);
        chk("t4_start_load_wr", 32'(wr_en), 32'd0);
        chk("t4_start_load_st", 32'(fft_start), 32'd0);
        chk("t4_start_load_state", 32'(state_o), 32'd1);
        sample_in = 8'hA3;
        drive(0, 1, 0, 0, 0);
        chk("t4_third_addr", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 2'd2, 8'hA3}));
        drive(1, 1, 0, 0, 0);
        chk("t4_clear_load_state", 32'(state_o), 32'd0);
        chk("t4_clear_load_wr", 32'(wr_en), 32'd0);

        // Asynchronous reset mid-LOAD
        drive(0, 1, 0, 0, 0);
        sample_in = 8'h5C;
        drive(0, 1, 0, 0, 0);
        chk("t5_pre_rst_wr", 32'(wr_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_load_rst_outs", 32'({state_o, wr_en, wr_addr, wr_data}), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("t5_load_rel", 32'({state_o, wr_en, fft_start}), 32'd0);

        // Asynchronous reset mid-RUN
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            sample_in = 8'(i + 1);
            drive(0, 1, 0, 0, 0);
        end
        drive(0, 0, 1, 0, 0);
        chk("t5_pre_rst_run", 32'({state_o, fft_start, busy}), 32'({3'd3, 1'b1, 1'b1}));
        rst = 1'b1;
        #1;
        chk("t5_run_rst_outs", 32'({state_o, fft_start, busy, err, wr_en, disp_idx}), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("t5_run_rel", 32'({state_o, fft_start, busy, wr_en}), 32'd0);
        tick();
        chk("t5_run_rel2", 32'({state_o, fft_start}), 32'd0);

        // Completion pulse while idle
        drive(0, 0, 0, 0, 1);
        chk("t5_done_idle", 32'({state_o, disp_idx, busy}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
